// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage between the instruction memory port and decode.
// Owns the fetch PC, issues in-order memory requests with valid/ready and
// buffers returned instructions, tagged with their addresses, in a
// DEPTH-entry prefetch queue. A branch redirects the fetch PC, flushes the
// queue and marks every response still in flight as stale. A decode stall
// simply holds the queue head.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - synchronous active-high reset
//   imem_req_valid - fetch request valid
//   imem_req_ready - memory accepts the request this cycle
//   imem_req_addr  - request address (the current fetch PC)
//   imem_rsp_valid - response valid; responses return in request order
//   imem_rsp_data  - returned instruction word
//   branch         - redirect fetch to branch_target this cycle
//   branch_target  - redirect address
//   stall          - decode cannot accept the head instruction
//   instr_valid    - queue head valid
//   instr          - head instruction (0 when instr_valid is low)
//   pc_out         - head instruction address (0 when instr_valid is low)
//   pc_next        - pc_out + PC_INC, wrapping (0 when instr_valid is low)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_BITS    = 16,
  parameter int INSTR_BITS = 32,
  parameter int PC_INC     = 4,
  parameter int RESET_PC   = 0,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_BITS-1:0]    imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_BITS-1:0] imem_rsp_data,
  input  logic                  branch,
  input  logic [PC_BITS-1:0]    branch_target,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [INSTR_BITS-1:0] instr,
  output logic [PC_BITS-1:0]    pc_out,
  output logic [PC_BITS-1:0]    pc_next
);

  localparam int PtrBits = $clog2(DEPTH);
  localparam int CntBits = $clog2(DEPTH + 1);

  localparam logic [PC_BITS-1:0] PcStep  = PC_BITS'(PC_INC);
  localparam logic [PC_BITS-1:0] ResetPc = PC_BITS'(RESET_PC);
  localparam logic [PtrBits-1:0] PtrOne  = PtrBits'(1);
  localparam logic [CntBits-1:0] CntOne  = CntBits'(1);
  localparam logic [CntBits:0]   Credit  = (CntBits + 1)'(DEPTH);

  logic [PC_BITS-1:0]    fpc;

  logic [PC_BITS-1:0]    qPc    [DEPTH];
  logic [INSTR_BITS-1:0] qInstr [DEPTH];
  logic [PtrBits-1:0]    qHead;
  logic [PtrBits-1:0]    qTail;
  logic [CntBits-1:0]    qCount;

  logic [PC_BITS-1:0]    fAddr  [DEPTH];
  logic [PtrBits-1:0]    fHead;
  logic [PtrBits-1:0]    fTail;
  logic [CntBits-1:0]    outstanding;
  logic [CntBits-1:0]    dropCount;

  logic [CntBits:0]      inUse;
  logic                  reqFire;
  logic                  rspFire;
  logic                  queuePush;
  logic                  headValid;
  logic                  queuePop;

  // Credit rule: every request in flight plus every buffered instruction
  // holds one queue slot, so a response can always be written without an
  // overflow check. Branch cycles issue nothing so the first request after
  // a redirect already uses the new target.
  // A response with nothing outstanding is spurious and ignored. Responses
  // are only kept when no stale ones remain and no flush is happening.
  always_comb begin
    inUse          = {1'b0, outstanding} + {1'b0, qCount};
    imem_req_valid = !rst && !branch && (inUse < Credit);
    imem_req_addr  = fpc;
    reqFire        = imem_req_valid && imem_req_ready;
    rspFire        = imem_rsp_valid && (outstanding != '0);
    queuePush      = !rst && rspFire && !branch && (dropCount == '0);
    headValid      = (qCount != '0);
    queuePop       = headValid && !stall && !branch;
  end

  // Fetch PC: a redirect wins over the sequential advance, which only
  // happens when memory actually takes the request, so the address holds
  // steady while the memory port back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= ResetPc;
    end else if (branch) begin
      fpc <= branch_target;
    end else if (reqFire) begin
      fpc <= fpc + PcStep;
    end
  end

  // In-flight address FIFO bookkeeping. It is never flushed by a branch:
  // stale responses still arrive in order and must pop their own entry so
  // the FIFO stays aligned with the memory's response stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      fHead       <= '0;
      fTail       <= '0;
      outstanding <= '0;
    end else begin
      if (reqFire) begin
        fTail <= fTail + PtrOne;
      end
      if (rspFire) begin
        fHead <= fHead + PtrOne;
      end
      outstanding <= outstanding + CntBits'(reqFire) - CntBits'(rspFire);
    end
  end

  // Address storage for requests in flight; contents only matter between
  // the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      fAddr[fTail] <= fpc;
    end
  end

  // Stale-response counter. On a redirect every request still in flight
  // becomes stale, except one whose response lands in the branch cycle
  // itself, since that one is already being thrown away right now.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropCount <= '0;
    end else if (branch) begin
      dropCount <= outstanding - CntBits'(rspFire);
    end else if (rspFire && (dropCount != '0)) begin
      dropCount <= dropCount - CntOne;
    end
  end

  // Prefetch queue pointers and occupancy; a branch empties it in one cycle.
  always_ff @(posedge clk) begin
    if (rst || branch) begin
      qHead  <= '0;
      qTail  <= '0;
      qCount <= '0;
    end else begin
      if (queuePush) begin
        qTail <= qTail + PtrOne;
      end
      if (queuePop) begin
        qHead <= qHead + PtrOne;
      end
      qCount <= qCount + CntBits'(queuePush) - CntBits'(queuePop);
    end
  end

  // Queue payload: each instruction is stored with the address of the
  // request it answers, taken from the head of the in-flight FIFO.
  always_ff @(posedge clk) begin
    if (queuePush) begin
      qPc[qTail]    <= fAddr[fHead];
      qInstr[qTail] <= imem_rsp_data;
    end
  end

  // Decode-side view of the queue head, forced to zero when empty.
  always_comb begin
    instr_valid = headValid;
    instr       = '0;
    pc_out      = '0;
    pc_next     = '0;
    if (headValid) begin
      instr   = qInstr[qHead];
      pc_out  = qPc[qHead];
      pc_next = qPc[qHead] + PcStep;
    end
  end

endmodule
